// File: rtl/hier_lane_pipeline.sv
// hier_lane_pipeline: CHANNELS parallel lanes. Each lane combines in0/in1 with
// one shared op (XOR/AND/OR/ADD). The results then pass through a DEPTH-stage
// stallable pipeline that uses one valid/ready handshake for all lanes.
// Stage ready is fully combinational, so bubbles collapse even while the sink
// stalls the pipeline.
// Optional feature: define HIER_LANE_PARITY_EN to add the out_parity port.
// That port gives the per-lane even parity of out_data.
module hier_lane_pipeline #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_mode,
  input  logic [CHANNELS*WIDTH-1:0] in0,
  input  logic [CHANNELS*WIDTH-1:0] in1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [15:0]               out_count
`ifdef HIER_LANE_PARITY_EN
  ,
  output logic [CHANNELS-1:0]       out_parity
`endif
);

  localparam int unsigned DW = CHANNELS * WIDTH;

  typedef enum logic [1:0] {
    OpXor = 2'd0,
    OpAnd = 2'd1,
    OpOr  = 2'd2,
    OpAdd = 2'd3
  } op_e;

  op_e             op;
  logic [DW-1:0]   op_result;
  logic [WIDTH-1:0] lane_a, lane_b, lane_r;
  logic [DEPTH:0]  rdy;
  logic            accept;
  logic [15:0]     count_q;

  assign op = op_e'(in_mode);

  // Apply the selected op lane by lane. ADD is truncated to WIDTH bits, so
  // no carry crosses into the next lane.
  always_comb begin
    op_result = '0;
    lane_a    = '0;
    lane_b    = '0;
    lane_r    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      lane_a = in0[i*WIDTH +: WIDTH];
      lane_b = in1[i*WIDTH +: WIDTH];
      case (op)
        OpXor:   lane_r = lane_a ^ lane_b;
        OpAnd:   lane_r = lane_a & lane_b;
        OpOr:    lane_r = lane_a | lane_b;
        OpAdd:   lane_r = lane_a + lane_b;
        default: lane_r = '0;
      endcase
      op_result[i*WIDTH +: WIDTH] = lane_r;
    end
  end

  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0] && !rst;
  assign accept     = in_valid && in_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          valid_q;
    logic [DW-1:0] data_q;

    // A stage can load when it is empty or its content moves on this cycle.
    assign rdy[k] = !valid_q || rdy[k+1];

    if (k == 0) begin : g_first
      // Stage 0 captures the combined operands from the input handshake.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (rdy[0]) begin
          valid_q <= accept;
          data_q  <= op_result;
        end
      end
    end else begin : g_next
      // Later stages take the content of the stage behind them.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (rdy[k]) begin
          valid_q <= g_stage[k-1].valid_q;
          data_q  <= g_stage[k-1].data_q;
        end
      end
    end
  end

  assign out_valid = g_stage[DEPTH-1].valid_q;
  assign out_data  = g_stage[DEPTH-1].data_q;

  // Count completed output beats. The count wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (out_valid && out_ready) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign out_count = count_q;

`ifdef HIER_LANE_PARITY_EN
  // Per-lane parity of the last stage, forced low while reset is asserted.
  always_comb begin
    out_parity = '0;
    if (!rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        out_parity[i] = ^out_data[i*WIDTH +: WIDTH];
      end
    end
  end
`endif

endmodule

// File: tb/tb_hier_lane_pipeline.sv
// Bench for hier_lane_pipeline at default parameters. It runs directed table
// vectors, then hand sequences for backpressure, mid-operation reset and
// counter wrap, then random traffic. A queue-based reference model predicts
// the outputs.
module tb_hier_lane_pipeline;

  localparam int W  = 2;
  localparam int CH = 2;
  localparam int D  = 2;
  localparam int DW = W * CH;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [DW-1:0] in0, in1;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [15:0]   out_count;
`ifdef HIER_LANE_PARITY_EN
  logic [CH-1:0] out_parity;
`endif

  hier_lane_pipeline #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .DEPTH    (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in0       (in0),
    .in1       (in1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
`ifdef HIER_LANE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: accepted beats in order, each tagged with its accept edge.
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } beat_t;

  beat_t       q[$];
  logic [15:0] m_count;
  int          edge_n;
  int          n_checks;
  int          n_fail;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Lane op computed with plain integer arithmetic.
  function automatic logic [DW-1:0] ref_op(input int m, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW-1:0] res;
    int la, lb, r, mask;
    res  = '0;
    mask = (1 << W) - 1;
    for (int i = 0; i < CH; i++) begin
      la = int'(a >> (i * W)) & mask;
      lb = int'(b >> (i * W)) & mask;
      case (m)
        0:       r = la ^ lb;
        1:       r = la & lb;
        2:       r = la | lb;
        default: r = (la + lb) % (1 << W);
      endcase
      res = res | (DW'(r) << (i * W));
    end
    return res;
  endfunction

  function automatic logic [CH-1:0] ref_par(input logic [DW-1:0] d);
    logic [CH-1:0] p;
    int            v;
    p = '0;
    for (int i = 0; i < CH; i++) begin
      v = int'(d >> (i * W)) & ((1 << W) - 1);
      for (int j = 0; j < W; j++) p[i] = p[i] ^ v[j];
    end
    return p;
  endfunction

  // One clock cycle: drive the inputs, check against the model, take the edge,
  // then update the model. Entry and exit are both 1 time unit after a posedge.
  task automatic cycle(input logic v, input logic [1:0] m, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic ordy, input logic [DW-1:0] exp_d);
    logic exp_rdy, exp_ov;
    in_valid  = v;
    in_mode   = m;
    in0       = a;
    in1       = b;
    out_ready = ordy;
    #1;
    exp_rdy = (q.size() < D) || ordy;
    // The oldest beat has nothing ahead of it. It therefore reaches the
    // last stage exactly D-1 edges after it is accepted.
    exp_ov  = (q.size() > 0) && (edge_n - q[0].t >= D);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      check("out_data", out_data, q[0].d);
`ifdef HIER_LANE_PARITY_EN
      check("out_parity", out_parity, ref_par(q[0].d));
`endif
    end
    check("out_count", out_count, m_count);
    @(posedge clk);
    if (exp_ov && ordy) begin
      void'(q.pop_front());
      m_count = m_count + 16'd1;
    end
    if (v && exp_rdy) q.push_back('{d: exp_d, t: edge_n});
    edge_n++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, '0, '0, 1'b1, '0);
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'd3;
    in0       = DW'($urandom);
    in1       = DW'($urandom);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_count", out_count, 16'd0);
`ifdef HIER_LANE_PARITY_EN
      check("rst_out_parity", out_parity, '0);
`endif
    end
    rst = 1'b0;
    q.delete();
    m_count = '0;
  endtask

  initial begin
    logic [1:0]    m;
    logic [DW-1:0] a, b;
    logic          v, r;

    n_checks  = 0;
    n_fail    = 0;
    edge_n    = 0;
    m_count   = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in0       = '0;
    in1       = '0;
    out_ready = 1'b0;

    tbl[0] = '{mode: 2'd0, a: 4'b1001, b: 4'b0101, exp: 4'b1100};
    tbl[1] = '{mode: 2'd1, a: 4'b1001, b: 4'b0101, exp: 4'b0001};
    tbl[2] = '{mode: 2'd2, a: 4'b1001, b: 4'b0101, exp: 4'b1101};
    tbl[3] = '{mode: 2'd3, a: 4'b1001, b: 4'b0101, exp: 4'b1110};
    // Both lanes 11+11 -> 10; a carry into the next lane would corrupt lane 1.
    tbl[4] = '{mode: 2'd3, a: 4'b1111, b: 4'b1111, exp: 4'b1010};

    do_reset(3);

    // Back-to-back streaming of the table vectors.
    for (int i = 0; i < 5; i++) cycle(1'b1, tbl[i].mode, tbl[i].a, tbl[i].b, 1'b1, tbl[i].exp);
    idle(D + 2);
    check("stream_count", out_count, 16'd5);

    // Backpressure: stall after the first beat, keep offering, then release.
    cycle(1'b1, 2'd0, 4'b0011, 4'b0101, 1'b1, ref_op(0, 4'b0011, 4'b0101));
    for (int i = 0; i < 4; i++) begin
      a = DW'(i + 1);
      cycle(1'b1, 2'd2, a, 4'b1000, 1'b0, ref_op(2, a, 4'b1000));
    end
    #1;
    check("bp_in_ready_held", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd3, 4'b0110, DW'(i), 1'b1, ref_op(3, 4'b0110, DW'(i)));
    idle(D + 3);

    // Reset with two beats in flight. Those beats must never appear, and the
    // next beat must arrive with the normal latency.
    cycle(1'b1, 2'd0, 4'b1111, 4'b0001, 1'b1, ref_op(0, 4'b1111, 4'b0001));
    cycle(1'b1, 2'd1, 4'b1111, 4'b0110, 1'b1, ref_op(1, 4'b1111, 4'b0110));
    do_reset(1);
    cycle(1'b1, 2'd2, 4'b0100, 4'b0001, 1'b1, ref_op(2, 4'b0100, 4'b0001));
    idle(D + 2);
    check("midrst_count", out_count, 16'd1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      m = 2'($urandom_range(0, 3));
      a = DW'($urandom);
      b = DW'($urandom);
      cycle(v, m, a, b, r, ref_op(int'(m), a, b));
    end
    idle(D + 4);

    // Counter wrap: 65535 completions, then one more beat. This beat gives
    // lane 0 = 10 and lane 1 = 00.
    do_reset(1);
    for (int i = 0; i < 65535; i++) begin
      m = 2'($urandom_range(0, 3));
      a = DW'($urandom);
      b = DW'($urandom);
      cycle(1'b1, m, a, b, 1'b1, ref_op(int'(m), a, b));
    end
    idle(D + 1);
    check("count_ffff", out_count, 16'hFFFF);
    cycle(1'b1, 2'd0, 4'b0110, 4'b0100, 1'b1, 4'b0010);
    idle(D + 1);
    check("count_wrap", out_count, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
